// File: rtl/dac_spi_tx_pkg.sv
// dac_spi_tx_pkg: frame geometry, FSM encoding and frame builder
// shared by the DAC SPI transmitter and its sample tick generator.
package dac_spi_tx_pkg;

    localparam int DAC_FRAME_LEN = 16;
    localparam int DAC_DATA_LEN  = 8;
    localparam int DAC_PAD_LEN   = 4;
    localparam int DAC_BIT_W     = $clog2(DAC_FRAME_LEN);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } dac_state_e;

    // {command nibble, sample, zero pad}, MSB shifted first
    function automatic logic [DAC_FRAME_LEN-1:0] dac_frame(
        input logic [3:0]              ctrl,
        input logic [DAC_DATA_LEN-1:0] sample
    );
        return {ctrl, sample, {DAC_PAD_LEN{1'b0}}};
    endfunction

endpackage

// File: rtl/dac_spi_tx_tick.sv
// sample_tick_gen: free-running divider that emits a one-cycle
// tick every SAMPLE_DIV cycles while en is high; held at 0 otherwise.
module sample_tick_gen
    import dac_spi_tx_pkg::*;
#(
    parameter int SAMPLE_DIV = 100
) (
    input  logic src_clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SAMPLE_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = en && (cnt_q == LAST);

    // next count: hold at zero when disabled, wrap after LAST
    always_comb begin
        cnt_d = cnt_q;
        if (!en) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // sample counter register
    always_ff @(posedge src_clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dac_spi_tx.sv
// dac_spi_tx: samples the DDS output and shifts 16-bit mode-0 SPI frames.
// Define DAC_TWOS_COMP_EN to invert the sample MSB (offset-binary -> 2's comp).
module dac_spi_tx
    import dac_spi_tx_pkg::*;
#(
    parameter int         CLK_DIV    = 2,
    parameter int         SAMPLE_DIV = 100,
    parameter logic [3:0] CTRL       = 4'b0011
) (
    input  logic                    src_clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [DAC_DATA_LEN-1:0] sinwave,
    input  logic                    ovr_clr,
    output logic                    dac_cs_n,
    output logic                    dac_sclk,
    output logic                    dac_mosi,
    output logic                    busy,
    output logic                    overrun
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DAC_BIT_W-1:0] LAST_FALL = DAC_BIT_W'(DAC_FRAME_LEN - 1);

`ifdef DAC_TWOS_COMP_EN
    localparam logic [DAC_DATA_LEN-1:0] SAMPLE_XOR = 8'h80;
`else
    localparam logic [DAC_DATA_LEN-1:0] SAMPLE_XOR = 8'h00;
`endif

    dac_state_e               state_q;
    logic [DIV_W-1:0]         div_q;
    logic [DAC_BIT_W-1:0]     fall_q;
    logic [DAC_FRAME_LEN-1:0] shreg_q;
    logic                     cs_n_q;
    logic                     sclk_q;
    logic                     mosi_q;
    logic                     busy_q;
    logic                     ovr_q;

    logic                     tick;
    logic                     div_done;
    logic [DAC_FRAME_LEN-1:0] frame_d;

    sample_tick_gen #(
        .SAMPLE_DIV(SAMPLE_DIV)
    ) u_tick (
        .src_clk(src_clk),
        .rst    (rst),
        .en     (en),
        .tick   (tick)
    );

    assign div_done = (div_q == DIV_LAST);
    assign frame_d  = dac_frame(CTRL, sinwave ^ SAMPLE_XOR);

    // sticky overrun: a tick landing on a busy frame; set beats clear
    always_ff @(posedge src_clk or posedge rst) begin
        if (rst) begin
            ovr_q <= 1'b0;
        end else if (tick && busy_q) begin
            ovr_q <= 1'b1;
        end else if (ovr_clr) begin
            ovr_q <= 1'b0;
        end
    end

    // frame FSM with SCLK divider, shift register and registered pins
    always_ff @(posedge src_clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            fall_q  <= '0;
            shreg_q <= '0;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (tick) begin
                        state_q <= SHIFT;
                        shreg_q <= frame_d;
                        mosi_q  <= frame_d[DAC_FRAME_LEN-1];
                        cs_n_q  <= 1'b0;
                        sclk_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        div_q   <= '0;
                        fall_q  <= '0;
                    end
                end
                SHIFT: begin
                    if (div_done) begin
                        div_q  <= '0;
                        sclk_q <= ~sclk_q;
                        // data moves only on the falling SCLK transition
                        if (sclk_q) begin
                            fall_q <= fall_q + 1'b1;
                            if (fall_q == LAST_FALL) begin
                                state_q <= HOLD;
                                cs_n_q  <= 1'b1;
                                mosi_q  <= 1'b0;
                            end else begin
                                mosi_q  <= shreg_q[DAC_FRAME_LEN-2];
                                shreg_q <= {shreg_q[DAC_FRAME_LEN-2:0], 1'b0};
                            end
                        end
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                HOLD: begin
                    // minimum CS-high time before the next frame
                    if (div_done) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        div_q   <= '0;
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign dac_cs_n = cs_n_q;
    assign dac_sclk = sclk_q;
    assign dac_mosi = mosi_q;
    assign busy     = busy_q;
    assign overrun  = ovr_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// tb_dac_spi_tx: two instances (default, and SAMPLE_DIV=40) driven with
// random samples; a pin-level DAC model captures frames for checking.
module tb_dac_spi_tx;

    localparam int C   = 2;
    localparam int SD0 = 100;
    localparam int SD1 = 40;

    logic       clk = 1'b0;
    logic [1:0] rst;
    logic [1:0] en;
    logic [1:0] clr;
    logic [7:0] sinwave;
    logic [1:0] cs_n;
    logic [1:0] sclk;
    logic [1:0] mosi;
    logic [1:0] busy;
    logic [1:0] ovr;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] hist [8192];

    typedef struct {
        int          dut;
        int          fall;
        logic [15:0] frame;
        int          rises;
        int          low;
    } frm_t;

    frm_t        fq[$];
    int          fall_c[2];
    int          low_c[2];
    int          rise_c[2];
    logic [15:0] sh[2];
    logic [1:0]  pcs   = 2'b11;
    logic [1:0]  psclk = 2'b00;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    dac_spi_tx u_dut0 (
        .src_clk (clk),
        .rst     (rst[0]),
        .en      (en[0]),
        .sinwave (sinwave),
        .ovr_clr (clr[0]),
        .dac_cs_n(cs_n[0]),
        .dac_sclk(sclk[0]),
        .dac_mosi(mosi[0]),
        .busy    (busy[0]),
        .overrun (ovr[0])
    );

    dac_spi_tx #(
        .CLK_DIV   (C),
        .SAMPLE_DIV(SD1)
    ) u_dut1 (
        .src_clk (clk),
        .rst     (rst[1]),
        .en      (en[1]),
        .sinwave (sinwave),
        .ovr_clr (clr[1]),
        .dac_cs_n(cs_n[1]),
        .dac_sclk(sclk[1]),
        .dac_mosi(mosi[1]),
        .busy    (busy[1]),
        .overrun (ovr[1])
    );

    // DAC model: shift mosi on each SCLK rise while CS is low
    always @(negedge clk) begin
        hist[cyc % 8192] = sinwave;
        for (int d = 0; d < 2; d++) begin
            if (pcs[d] && !cs_n[d]) begin
                fall_c[d] = cyc;
                low_c[d]  = 0;
                rise_c[d] = 0;
                sh[d]     = '0;
            end
            if (!cs_n[d]) begin
                low_c[d]++;
                if (!psclk[d] && sclk[d]) begin
                    sh[d] = {sh[d][14:0], mosi[d]};
                    rise_c[d]++;
                end
            end
            if (!pcs[d] && cs_n[d])
                fq.push_back('{d, fall_c[d], sh[d], rise_c[d], low_c[d]});
        end
        pcs   = cs_n;
        psclk = sclk;
    end

    function automatic logic [15:0] exp_frame(input logic [7:0] s);
        logic [7:0] v;
        v = s;
`ifdef DAC_TWOS_COMP_EN
        v[7] = ~v[7];
`endif
        return {4'b0011, v, 4'b0000};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_frame(input string tag, input frm_t f,
                             input int tick_c);
        chk({tag, "_fall"},  f.fall,  tick_c + 1);
        chk({tag, "_data"},  f.frame, exp_frame(hist[(tick_c) % 8192]));
        chk({tag, "_rises"}, f.rises, 16);
        chk({tag, "_cslow"}, f.low,   32 * C);
    endtask

    task automatic frames_of(input int d, output frm_t q[$]);
        q.delete();
        foreach (fq[k]) if (fq[k].dut == d) q.push_back(fq[k]);
    endtask

    initial begin
        frm_t got[$];
        int   ticks[$];
        int   e;
        int   free_at;
        logic found;
        logic [15:0] a5;

        rst     = 2'b11;
        en      = 2'b00;
        clr     = 2'b00;
        sinwave = 8'h00;

        // reset held with en low: all outputs idle
        repeat (10) begin
            @(negedge clk);
            chk("rst_idle0", {cs_n[0], sclk[0], mosi[0], busy[0], ovr[0]}, 5'b10000);
            chk("rst_idle1", {cs_n[1], sclk[1], mosi[1], busy[1], ovr[1]}, 5'b10000);
        end

        // sample rate: 1000 cycles of en, one frame per SD0 cycles
        @(posedge clk); #1;
        rst   = 2'b00;
        en[0] = 1'b1;
        e     = cyc;
        for (int i = 0; i < 1000; i++) begin
            sinwave = (i == SD0 - 1) ? 8'hA5 : 8'($urandom);
            @(posedge clk); #1;
        end
        en[0] = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        frames_of(0, got);
        chk("rate_nframes", got.size(), 10);
        for (int k = 0; k < 10 && k < got.size(); k++)
            chk_frame("rate", got[k], e + SD0 - 1 + SD0 * k);
`ifdef DAC_TWOS_COMP_EN
        a5 = 16'h3250;
`else
        a5 = 16'h3A50;
`endif
        if (got.size() > 0) chk("a5_frame", got[0].frame, a5);
        chk("rate_overrun", ovr[0], 1'b0);
        chk("rate_busy_end", busy[0], 1'b0);
        fq.delete();

        // overrun: SAMPLE_DIV=40 is shorter than a 67-cycle frame
        @(posedge clk); #1;
        en[1] = 1'b1;
        e     = cyc;
        for (int i = 0; i < 200; i++) begin
            sinwave = 8'($urandom);
            clr[1]  = (i == 100 || i == 159 || i == 170);
            @(negedge clk);
            if (i == 79)  chk("ovr_before", ovr[1], 1'b0);
            if (i == 79)  chk("busy_at_tick2", busy[1], 1'b1);
            if (i == 80)  chk("ovr_set", ovr[1], 1'b1);
            if (i == 105) chk("busy_last", busy[1], 1'b1);
            if (i == 106) chk("busy_done", busy[1], 1'b0);
            if (i == 101) chk("ovr_clr", ovr[1], 1'b0);
            if (i == 160) chk("ovr_set_wins", ovr[1], 1'b1);
            if (i == 171) chk("ovr_clr2", ovr[1], 1'b0);
            @(posedge clk); #1;
        end
        clr[1] = 1'b0;
        en[1]  = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        free_at = 0;
        ticks.delete();
        for (int t = e + SD1 - 1; t < e + 200; t += SD1) begin
            if (t >= free_at) begin
                ticks.push_back(t);
                free_at = t + 1 + 33 * C;
            end
        end
        frames_of(1, got);
        chk("ovr_nframes", got.size(), ticks.size());
        for (int k = 0; k < ticks.size() && k < got.size(); k++)
            chk_frame("ovr", got[k], ticks[k]);
        fq.delete();

        // reset after the 5th SCLK rise of a frame
        @(posedge clk); #1;
        en[0] = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            sinwave = 8'($urandom);
            @(negedge clk); #1;
            if (!cs_n[0] && rise_c[0] == 5) found = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        chk("rise5_seen", found, 1'b1);
        @(posedge clk); #1;
        rst[0] = 1'b1;
        #1;
        chk("midrst_cs", cs_n[0], 1'b1);
        chk("midrst_sclk", sclk[0], 1'b0);
        chk("midrst_mosi", mosi[0], 1'b0);
        chk("midrst_busy", busy[0], 1'b0);
        @(posedge clk); #1;
        frames_of(0, got);
        chk("partial_n", got.size(), 1);
        if (got.size() > 0) chk("partial_rises", got[0].rises, 5);
        fq.delete();
        rst[0] = 1'b0;
        e      = cyc;
        for (int i = 0; i < 200; i++) begin
            sinwave = 8'($urandom);
            if (i == 150) en[0] = 1'b0;
            @(posedge clk); #1;
        end
        frames_of(0, got);
        chk("post_rst_n", got.size(), 1);
        if (got.size() > 0) chk_frame("post_rst", got[0], e + SD0 - 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
